// File: rtl/ecc_pkg.sv
// Shared Hamming(7,4) definitions: codeword type, bit positions, encoder states and
// the reference nibble encoder used by both the encoder and the downstream decoder.
package ecc_pkg;

  typedef logic [6:0] hamming74_cw_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } enc_state_t;

  // Codeword layout {D3,D2,D1,P4,D0,P2,P1}
  localparam int unsigned CW_P1 = 0;
  localparam int unsigned CW_P2 = 1;
  localparam int unsigned CW_D0 = 2;
  localparam int unsigned CW_P4 = 3;
  localparam int unsigned CW_D1 = 4;
  localparam int unsigned CW_D2 = 5;
  localparam int unsigned CW_D3 = 6;

  function automatic hamming74_cw_t hamming74_encode(input logic [3:0] d);
    hamming74_cw_t cw;
    cw        = '0;
    cw[CW_D0] = d[0];
    cw[CW_D1] = d[1];
    cw[CW_D2] = d[2];
    cw[CW_D3] = d[3];
    cw[CW_P1] = d[0] ^ d[1] ^ d[3];
    cw[CW_P2] = d[0] ^ d[2] ^ d[3];
    cw[CW_P4] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

endpackage

// File: rtl/hamming74_enc_core.sv
// Combinational nibble -> Hamming(7,4) codeword with optional single-bit flip.
// err_pos 0 leaves the codeword clean; 1..7 flips codeword bit err_pos-1.
module hamming74_enc_core
  import ecc_pkg::*;
(
  input  logic [3:0]    i_nibble,
  input  logic [2:0]    i_err_pos,
  output hamming74_cw_t o_cw,
  output logic          o_inj
);

  hamming74_cw_t w_clean;
  hamming74_cw_t w_flip;

  always_comb begin
    w_clean = hamming74_encode(i_nibble);
    w_flip  = '0;
    if (i_err_pos != 3'd0) begin
      w_flip = 7'd1 << (i_err_pos - 3'd1);
    end
  end

  assign o_cw  = w_clean ^ w_flip;
  assign o_inj = (i_err_pos != 3'd0);

endmodule

// File: rtl/hamming_byte_encoder_tx.sv
// Byte -> two Hamming(7,4) codewords, one per cycle; first codeword valid the cycle after
// acceptance. Output holds under backpressure; a new byte is taken only while the last codeword leaves.
module hamming_byte_encoder_tx
  import ecc_pkg::*;
#(
  parameter bit LO_FIRST = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  input  logic [2:0]       err_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_codeword,
  output logic             out_last,
  output logic [CNT_W-1:0] cw_count,
  output logic [CNT_W-1:0] inj_count
);

  enc_state_t    r_state;
  enc_state_t    w_state_nxt;

  logic [7:0]    r_byte;
  hamming74_cw_t r_cw;
  logic          r_last;
  logic          r_inj;
  logic [CNT_W-1:0] r_cw_count;
  logic [CNT_W-1:0] r_inj_count;

  logic          w_accept;
  logic          w_load;
  logic          w_sel_second;
  logic          w_take_hi;
  logic [7:0]    w_src_byte;
  logic [3:0]    w_nibble;
  hamming74_cw_t w_cw;
  logic          w_inj;
  logic          w_handoff;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_sel_second = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = FIRST;
        end
      end
      FIRST: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_load       = 1'b1;
          w_sel_second = 1'b1;
          w_state_nxt  = SECOND;
        end
      end
      SECOND: begin
        out_valid = 1'b1;
        in_ready  = out_ready && !rst;
        if (out_ready) begin
          if (in_valid) begin
            w_accept    = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = FIRST;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The second codeword always comes from the latched byte; the first from the live input.
  always_comb begin
    w_src_byte = w_sel_second ? r_byte : in_byte;
    w_take_hi  = LO_FIRST ? w_sel_second : !w_sel_second;
    w_nibble   = w_take_hi ? w_src_byte[7:4] : w_src_byte[3:0];
  end

  hamming74_enc_core u_enc_core (
    .i_nibble  (w_nibble),
    .i_err_pos (err_pos),
    .o_cw      (w_cw),
    .o_inj     (w_inj)
  );

  assign w_handoff = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte <= '0;
      r_cw   <= '0;
      r_last <= 1'b0;
      r_inj  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_byte <= in_byte;
      end
      if (w_load) begin
        r_cw   <= w_cw;
        r_inj  <= w_inj;
        r_last <= w_sel_second;
      end else if (w_handoff) begin
        r_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cw_count  <= '0;
      r_inj_count <= '0;
    end else if (w_handoff) begin
      r_cw_count <= r_cw_count + CNT_W'(1);
      if (r_inj) begin
        r_inj_count <= r_inj_count + CNT_W'(1);
      end
    end
  end

  assign out_codeword = r_cw;
  assign out_last     = r_last;
  assign cw_count     = r_cw_count;
  assign inj_count    = r_inj_count;

endmodule
